seq_chunk_adder: RTL and testbench
==================================

Name: seq_chunk_adder

Overview:
- Multi-cycle add/subtract unit for wide operands.
- Processes CHUNK bits per clock through one CHUNK-bit ripple stage and keeps the carry in a register between chunks.
- Replaces a full-width ripple chain where area matters more than latency.
- Sits between operand producers and consumers, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32: operand and result width in bits.
- CHUNK, 8: bits processed per cycle. WIDTH must be a multiple of CHUNK. NCHUNK = WIDTH/CHUNK must be at least 2.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands are valid.
- in_ready  out  1  block can accept operands.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- cin  in  1  carry-in for add, borrow-in for subtract.
- sub  in  1  0 selects A+B+cin; 1 selects A-B-cin.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- Y  out  WIDTH  result.
- cout  out  1  final carry. For subtract, 1 means no borrow.

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, Y=0, cout=0, chunk counter=0, carry register=0. Reset is asynchronous and may hit any state; an in-flight operation is discarded with no output.
- States: IDLE, RUN, DONE. in_ready = (state==IDLE) and is combinational from state only.
- IDLE:
  - On in_valid & in_ready, capture A, and B or ~B when sub=1.
  - Carry register loads cin XOR sub.
  - Clear Y and the counter, then go to RUN.
  - Operand inputs may change after the capture edge.
- RUN:
  - Each cycle, add the lowest CHUNK bits of the A and B shift registers plus the carry register.
  - Write the sum into Y by right-shift insertion, so after NCHUNK cycles the chunks sit in their natural positions.
  - Update the carry register, shift both operand registers right by CHUNK, and increment the counter.
  - After the edge that processes chunk NCHUNK-1, go to DONE with cout = final carry.
- Latency: out_valid rises exactly NCHUNK cycles after the accept edge.
- DONE:
  - out_valid=1; Y and cout are held stable until out_ready=1.
  - On out_valid & out_ready, go to IDLE; out_valid drops on the next edge.
  - A new input cannot be accepted in the same cycle as a DONE handshake, so there is a minimum one-cycle bubble.
  - Throughput is one operation per NCHUNK+2 cycles.
- Arithmetic:
  - Y = (A + B + cin) mod 2^WIDTH when sub=0.
  - Y = (A + ~B + ~cin) mod 2^WIDTH = A - B - cin when sub=1.
- Boundary conditions:
  - All-ones + 1 wraps to 0 with cout=1.
  - 0 - 1 wraps to all-ones with cout=0.
  - in_valid asserted in RUN or DONE is ignored; in_ready=0 there.

Optional Feature:
- Macro: SEQ_ADDER_OVF_EN.
- Defined: an extra output port ovf (1 bit) is added. It is set in DONE to signed two's-complement overflow, computed as the carry into the MSB XOR the carry out of the MSB from the final chunk. It is reset to 0, held with Y, and cleared on accept.
- Undefined: the port and its logic are absent; everything else is identical.

Decomposition:
- Package adder_pkg holds:
  - the state typedef (IDLE, RUN, DONE, 2-bit encoding);
  - a function computing counter width, clog2(NCHUNK);
  - an elaboration check constant for WIDTH % CHUNK == 0.
- Sub-module chunk_adder: purely combinational CHUNK-bit ripple adder (a, b, cin → sum, cout, plus c_msb_in for the overflow feature). It is instantiated once.
- All sequential logic stays in seq_chunk_adder.

Test Plan (WIDTH=16, CHUNK=4):
- Add with wrap: A=0xFFFF, B=0x0001, cin=0, sub=0 → Y=0x0000, cout=1; out_valid rises 4 cycles after the accept edge.
- Subtract with borrow-in: A=0x1234, B=0x0235, cin=1, sub=1 → Y=0x0FFE, cout=1.
- Subtract underflow: A=0x0000, B=0x0001, cin=0, sub=1 → Y=0xFFFF, cout=0.
- Backpressure and re-accept: hold out_ready=0 for 5 cycles → Y stays stable and in_ready=0. Then pulse out_ready with in_valid held high → next operand accepted exactly one cycle after the DONE handshake.
- Reset mid-run: assert rst_n=0 two cycles after accept → out_valid=0, Y=0, in_ready=1 immediately without a clock edge. A fresh 0x0003+0x0004 then gives 0x0007.
- With SEQ_ADDER_OVF_EN: A=0x7FFF, B=0x0001, sub=0 → Y=0x8000, ovf=1, cout=0. Then A=0xFFFF, B=0x0001 → ovf=0, cout=1.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the chunked adder.
// Holds the FSM state encoding, counter sizing and the geometry check.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Chunk counter width; at least one bit so the counter always exists.
    function automatic int cnt_width(input int nchunk);
        return (nchunk < 2) ? 1 : $clog2(nchunk);
    endfunction

    // Operand width must split into two or more whole chunks.
    function automatic bit chunk_ok(input int width, input int chunk);
        return (chunk > 0) && (width % chunk == 0) && (width / chunk >= 2);
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational WIDTH-bit ripple adder used as one slice of a wide add.
// Ports: a, b, cin -> sum, cout, c_msb_in (carry into the top bit).
module chunk_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic c;

    always_comb begin
        sum      = '0;
        c_msb_in = 1'b0;
        c        = cin;
        for (int i = 0; i < WIDTH; i++) begin
            if (i == WIDTH - 1) begin
                c_msb_in = c;
            end
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract: one CHUNK-bit ripple slice per clock, carry kept in a register.
// Ports: clk, rst_n, in_valid/in_ready, A, B, cin, sub, out_valid/out_ready, Y, cout
// (+ ovf when SEQ_ADDER_OVF_EN is defined).
module seq_chunk_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             cout
`ifdef SEQ_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = cnt_width(NCHUNK);
    localparam bit CFG_OK = chunk_ok(WIDTH, CHUNK);
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    generate
        if (!CFG_OK) begin : g_bad_cfg
            $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK with >= 2 chunks");
        end
    endgenerate

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] y_r;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             cout_r;

    logic [CHUNK-1:0] sum;
    logic             c_out;
`ifdef SEQ_ADDER_OVF_EN
    logic             c_msb;
    logic             ovf_r;
`else
    logic             c_msb_unused;
`endif

    chunk_adder #(
        .WIDTH(CHUNK)
    ) u_slice (
        .a        (a_sh[CHUNK-1:0]),
        .b        (b_sh[CHUNK-1:0]),
        .cin      (carry),
        .sum      (sum),
        .cout     (c_out),
`ifdef SEQ_ADDER_OVF_EN
        .c_msb_in (c_msb)
`else
        .c_msb_in (c_msb_unused)
`endif
    );

    wire accept = in_valid && in_ready;
    wire last   = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath. Subtract is A + ~B + ~cin, so B is inverted at capture
    // and the initial carry is cin ^ sub.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            y_r    <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
`ifdef SEQ_ADDER_OVF_EN
            ovf_r  <= 1'b0;
`endif
        end else begin
            if (accept) begin
                a_sh  <= A;
                b_sh  <= sub ? ~B : B;
                carry <= cin ^ sub;
                y_r   <= '0;
                cnt   <= '0;
`ifdef SEQ_ADDER_OVF_EN
                ovf_r <= 1'b0;
`endif
            end else if (state == RUN) begin
                // New chunk enters at the top; after NCHUNK shifts
                // every chunk lands in its natural position.
                y_r   <= {sum, y_r[WIDTH-1:CHUNK]};
                carry <= c_out;
                a_sh  <= a_sh >> CHUNK;
                b_sh  <= b_sh >> CHUNK;
                cnt   <= cnt + CW'(1);
                if (last) begin
                    cout_r <= c_out;
`ifdef SEQ_ADDER_OVF_EN
                    ovf_r  <= c_msb ^ c_out;
`endif
                end
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign Y         = y_r;
    assign cout      = cout_r;
`ifdef SEQ_ADDER_OVF_EN
    assign ovf       = ovf_r;
`endif

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder at WIDTH=16, CHUNK=4.
// Covers wrap, subtract, underflow, backpressure, re-accept, async reset, ovf.
module tb_seq_chunk_adder;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Y;
    logic         cout;
`ifdef SEQ_ADDER_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    seq_chunk_adder #(
        .WIDTH(W),
        .CHUNK(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (Y),
        .cout      (cout)
`ifdef SEQ_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Present operands, accept, and wait for out_valid (bounded).
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic c, input logic s, input string tag);
        int n;
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        A = a;
        B = b;
        cin = c;
        sub = s;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = '1;
        B = '1;
        cin = ~c;
        sub = ~s;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd4);
    endtask

    task automatic finish_op(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_ir_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [W-1:0] held;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        A = '0;
        B = '0;
        cin = 1'b0;
        sub = 1'b0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_y", 32'(Y), 32'h0);
        check("rst_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "wrap");
        check("wrap_y", 32'(Y), 32'h0000);
        check("wrap_cout", 32'(cout), 32'd1);
`ifdef SEQ_ADDER_OVF_EN
        check("wrap_ovf", 32'(ovf), 32'd0);
`endif
        finish_op("wrap");

        start_op(16'h1234, 16'h0235, 1'b1, 1'b1, "subb");
        check("subb_y", 32'(Y), 32'h0FFE);
        check("subb_cout", 32'(cout), 32'd1);
        finish_op("subb");

        start_op(16'h0000, 16'h0001, 1'b0, 1'b1, "uflow");
        check("uflow_y", 32'(Y), 32'hFFFF);
        check("uflow_cout", 32'(cout), 32'd0);

        // Backpressure: result held, new operands ignored while in DONE.
        held = Y;
        @(negedge clk);
        in_valid = 1'b1;
        A = 16'h0100;
        B = 16'h0023;
        cin = 1'b0;
        sub = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_y", 32'(Y), 32'(held));
            check("bp_ir", 32'(in_ready), 32'd0);
            check("bp_ov", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("hs_ir", 32'(in_ready), 32'd1);
        check("hs_ov", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("reacc_ir", 32'(in_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("reacc_wait", 32'(out_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        check("reacc_ov", 32'(out_valid), 32'd1);
        check("reacc_y", 32'(Y), 32'h0123);
        check("reacc_cout", 32'(cout), 32'd0);
        finish_op("reacc");

        // Asynchronous reset two cycles into a run.
        @(negedge clk);
        in_valid = 1'b1;
        A = 16'hABCD;
        B = 16'h1111;
        cin = 1'b0;
        sub = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ov", 32'(out_valid), 32'd0);
        check("arst_y", 32'(Y), 32'h0);
        check("arst_ir", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        start_op(16'h0003, 16'h0004, 1'b0, 1'b0, "fresh");
        check("fresh_y", 32'(Y), 32'h0007);
        check("fresh_cout", 32'(cout), 32'd0);
        finish_op("fresh");

`ifdef SEQ_ADDER_OVF_EN
        start_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, "ovf1");
        check("ovf1_y", 32'(Y), 32'h8000);
        check("ovf1_ovf", 32'(ovf), 32'd1);
        check("ovf1_cout", 32'(cout), 32'd0);
        finish_op("ovf1");
        start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "ovf0");
        check("ovf0_y", 32'(Y), 32'h0000);
        check("ovf0_ovf", 32'(ovf), 32'd0);
        check("ovf0_cout", 32'(cout), 32'd1);
        finish_op("ovf0");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
